// File: rtl/sv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sv_rr_arbiter
//   Eight-requester round-robin arbiter with a bounded hold time. A requester
//   may keep the grant for up to MAX_HOLD consecutive cycles while others
//   wait; if nobody else is waiting it keeps the grant indefinitely. All
//   outputs are registered, so a decision taken at a clock edge is visible
//   right after that edge.
//
// Parameters
//   MAX_HOLD  consecutive grant cycles allowed while others wait (1..15)
//
// Ports
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   request   [7:0] one bit per requester, high = wants the resource
//   grant     [2:0] index of the current owner (meaningful while valid=1)
//   grant_oh  [7:0] one-hot form of grant, all zeros while valid=0
//   valid     high while some requester holds the grant
// -----------------------------------------------------------------------------
module sv_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] request,
  output logic [2:0] grant,
  output logic [7:0] grant_oh,
  output logic       valid
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] cnt;

  // First set bit of mask, searching upward from start and wrapping 7->0.
  // The loop walks offsets from highest to lowest so the nearest hit is the
  // last one written and wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask,
                                         input logic [2:0] start);
    logic [2:0] idx;
    rr_pick = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  // Candidate for the next grant. From IDLE the search starts at ptr; while
  // granting it starts just past the current owner. When the owner still
  // requests, the owner is masked out so an expired hold passes the grant on.
  logic [2:0] search_start;
  logic [7:0] search_mask;
  logic [7:0] others;
  logic [2:0] next_grant;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    others       = request & ~grant_oh;
    search_start = ptr;
    search_mask  = request;
    if (state == GRANT) begin
      search_start = grant + 3'd1;
      if (request[grant]) search_mask = others;
    end
    next_grant = rr_pick(search_mask, search_start);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 3'd0;
      grant_oh <= 8'd0;
      valid    <= 1'b0;
      ptr      <= 3'd0;
      cnt      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // With no request, grant and ptr simply hold.
          if (|request) begin
            state    <= GRANT;
            valid    <= 1'b1;
            grant    <= next_grant;
            grant_oh <= 8'd1 << next_grant;
            ptr      <= next_grant + 3'd1;
            cnt      <= 4'd1;
          end
        end

        GRANT: begin
          if (request == 8'd0) begin
            // Release: grant keeps its last value, only valid/grant_oh drop.
            state    <= IDLE;
            valid    <= 1'b0;
            grant_oh <= 8'd0;
            cnt      <= 4'd0;
          end else if (!request[grant] || (cnt == MAX_HOLD_C && |others)) begin
            // Owner left, or its hold expired with someone else waiting:
            // hand over directly, no idle bubble.
            grant    <= next_grant;
            grant_oh <= 8'd1 << next_grant;
            ptr      <= next_grant + 3'd1;
            cnt      <= 4'd1;
          end else if (cnt == MAX_HOLD_C) begin
            // Hold expired but nobody else wants it: keep it, restart count.
            cnt <= 4'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sv_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sv_rr_arbiter
//   Directed self-checking bench for sv_rr_arbiter with MAX_HOLD=4. Inputs
//   change on the falling edge; outputs are sampled on the falling edge, half
//   a period after the rising edge that produced them.
// -----------------------------------------------------------------------------
module tb_sv_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] request;
  logic [2:0] grant;
  logic [7:0] grant_oh;
  logic       valid;

  int passed = 0;
  int total  = 0;

  sv_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .request  (request),
    .grant    (grant),
    .grant_oh (grant_oh),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Checks valid, grant and grant_oh together; grant_oh follows from the
  // expected valid and grant.
  task automatic check_out(input string tag, input logic exp_valid,
                           input logic [2:0] exp_grant);
    logic [7:0] exp_oh;
    exp_oh = exp_valid ? (8'd1 << exp_grant) : 8'd0;
    check({tag, ".valid"},    32'(valid),    32'(exp_valid));
    check({tag, ".grant"},    32'(grant),    32'(exp_grant));
    check({tag, ".grant_oh"}, 32'(grant_oh), 32'(exp_oh));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [2:0] seq_025 [9];

  initial begin
    seq_025 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd1};

    // Reset with every requester asking: outputs held low.
    rst_n   = 1'b0;
    request = 8'hFF;
    #2;
    check_out("reset_hold", 1'b0, 3'd0);
    tick();
    check_out("reset_over_edge", 1'b0, 3'd0);
    rst_n = 1'b1;

    // First edge after release grants 0; hold lasts four cycles, then the
    // grant moves to 1 even though 0 still requests.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("ff_hold%0d", i), 1'b1, 3'd0);
    end
    tick();
    check_out("ff_hold_expire", 1'b1, 3'd1);

    // Fresh reset, then two requesters alternate every four cycles.
    rst_n = 1'b0;
    #1;
    check_out("async_reset_mid", 1'b0, 3'd0);
    tick();
    rst_n   = 1'b1;
    request = 8'b0000_1010;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_out($sformatf("alt%0d", i), 1'b1, seq_025[i]);
    end

    // Only requester 5: owner 1 dropped, so grant moves to 5 at once.
    request = 8'h20;
    tick();
    check_out("r5_c1", 1'b1, 3'd5);
    tick();
    check_out("r5_c2", 1'b1, 3'd5);
    request = 8'h00;
    tick();
    check_out("r5_release", 1'b0, 3'd5);
    tick();
    check_out("idle_hold", 1'b0, 3'd5);

    // From IDLE (ptr=6) grant 2, then search from 3 picks 6 over 0.
    request = 8'h04;
    tick();
    check_out("g2", 1'b1, 3'd2);
    request = 8'b0100_0001;
    tick();
    check_out("g6_from3", 1'b1, 3'd6);
    request = 8'b0000_0001;
    tick();
    check_out("g0_after6", 1'b1, 3'd0);

    // Lone requester 7 for ten cycles: no drop across hold reloads.
    request = 8'h80;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out($sformatf("r7_%0d", i), 1'b1, 3'd7);
    end
    // Count is now 2 (reloaded at cycles 5 and 9): two more cycles of 7,
    // then the waiting requester 0 takes over.
    request = 8'h81;
    tick();
    check_out("r7_cnt3", 1'b1, 3'd7);
    tick();
    check_out("r7_cnt4", 1'b1, 3'd7);
    tick();
    check_out("r7_to_0", 1'b1, 3'd0);

    // Move to grant 3, then pulse reset between edges.
    request = 8'b0000_1000;
    tick();
    check_out("g3", 1'b1, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("pulse_reset", 1'b0, 3'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check_out("g3_after_reset", 1'b1, 3'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sv_rr_arbiter.md
SV_RR_ARBITER -- requirements
Module: sv_rr_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per requester while others wait (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port request, input, 8 bits, one bit per requester; bit i high means requester i wants the resource.
REQ-005 The block SHALL have port grant, output, 3 bits, index of the requester currently granted (meaningful only while valid=1).
REQ-006 The block SHALL have port grant_oh, output, 8 bits, one-hot form of grant; all zeros when valid=0.
REQ-007 The block SHALL have port valid, output, 1 bit, high while any requester holds the grant.

Function
REQ-008 The block SHALL register all outputs; an arbitration decision made at edge N is visible after edge N, with one-cycle latency from request to grant.
REQ-009 The block SHALL implement two states: IDLE (valid=0) and GRANT (valid=1).
REQ-010 The block SHALL keep a 3-bit rotation pointer ptr; rr_pick(mask, start) selects the first set bit of mask searching upward from index start, wrapping 7->0.
REQ-011 Every new grant g SHALL set ptr to (g+1) mod 8, using 3-bit wrap arithmetic.
REQ-012 The block SHALL keep a 4-bit hold counter cnt; cnt is 1 in the first granted cycle and increments each following cycle the same grant is held.
REQ-013 In IDLE with request!=0, the block SHALL next set grant=rr_pick(request, ptr), valid=1, cnt=1, and go to GRANT.
REQ-014 In IDLE with request==0, the block SHALL stay in IDLE; grant and ptr SHALL hold their values.
REQ-015 In GRANT with request[grant]==0 and other bits set, the block SHALL next grant rr_pick(request, grant+1) with cnt=1 and valid staying 1, with no idle bubble.
REQ-016 In GRANT with request==0, the block SHALL next go to IDLE with valid=0 and grant_oh=0; grant SHALL keep its last value.
REQ-017 In GRANT with request[grant]==1, cnt==MAX_HOLD, and other requests pending, the block SHALL next grant rr_pick(request & ~grant_oh, grant+1) with cnt=1.
REQ-018 In GRANT with request[grant]==1, cnt==MAX_HOLD, and no other request pending, the block SHALL keep the same grant and reload cnt=1.
REQ-019 In GRANT with request[grant]==1 and cnt<MAX_HOLD, the block SHALL keep the grant and increment cnt.
REQ-020 The block SHALL drive grant_oh = valid ? (1<<grant) : 0 at all times.
REQ-021 The block SHALL grant at most one requester at any time; a requester with a bit set and no grant SHALL be granted within 7*MAX_HOLD+1 cycles.

Reset
REQ-022 While rst_n=0, the block SHALL immediately hold grant=0, grant_oh=0, valid=0, ptr=0, cnt=0, state=IDLE, regardless of clk.
REQ-023 Reset asserted mid-grant SHALL drop the grant at once; after release, arbitration SHALL restart from ptr=0.

Verification (MAX_HOLD=4)
REQ-024 Scenario: rst_n=0 with request=8'hFF -> valid=0, grant_oh=0; after release, first edge -> grant=0, valid=1, grant_oh=8'h01.
REQ-025 Scenario: request=8'b00001010 held from IDLE -> grant=1 for 4 cycles, grant=3 for 4 cycles, then grant=1 again, with no valid gaps.
REQ-026 Scenario: only request[5] high for 2 cycles, then 0 -> grant=5, valid=1 for 2 cycles; next cycle valid=0, grant_oh=0, grant stays 5.
REQ-027 Scenario: grant=2, request changes to 8'b01000001 -> next cycle grant=6 (search from 3), valid stays 1; after 6 drops, grant=0.
REQ-028 Scenario: only request[7] held 10 cycles -> grant=7, valid=1 continuously; cnt reloads to 1 at 4 and no re-arbitration glitch.
REQ-029 Scenario: rst_n pulsed low between clock edges during grant=3 -> valid, grant_oh, and grant go to 0 before the next edge; with request=8'b00001000 after release -> grant=3 one edge later.
